// File: rtl/stage3_hazard_ctrl.sv
// stage3_hazard_ctrl: pipeline control for the fetch/execute/mem RV32I core.
// Resolves mem-stage control transfers, sequences the fence.i / CSR
// serialization flush, and generates stall, flush and forwarding controls.
module stage3_hazard_ctrl #(
    parameter int unsigned IFLUSH_TIMEOUT = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imem_busy,
    input  logic        dmem_busy,
    input  logic        mem_valid,
    input  logic        brj_taken,
    input  logic [31:0] brj_addr,
    input  logic [31:0] pc4,
    input  logic        serialize,
    input  logic        fence_i,
    input  logic        iflush_done,
    input  logic [4:0]  rs1_e,
    input  logic [4:0]  rs2_e,
    input  logic [4:0]  rd_m,
    input  logic        reg_write,
    output logic        stall_fetch,
    output logic        stall_execute,
    output logic        stall_mem,
    output logic        flush_fetch,
    output logic        flush_execute,
    output logic        redirect,
    output logic [31:0] redirect_addr,
    output logic        iflush_req,
    output logic        iflush_err,
    output logic        fwd_rs1,
    output logic        fwd_rs2
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        REFETCH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IFLUSH_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       saved_pc_q, saved_pc_d;
    logic              iflush_err_q, iflush_err_d;
    logic              res;

    assign res = mem_valid & ~dmem_busy;

    // State, flush-wait counter, saved refetch PC and sticky timeout flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            saved_pc_q   <= '0;
            iflush_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            saved_pc_q   <= saved_pc_d;
            iflush_err_q <= iflush_err_d;
        end
    end

    // Next-state and all pipeline controls; outputs forced low while in reset.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        saved_pc_d    = saved_pc_q;
        iflush_err_d  = iflush_err_q;
        stall_fetch   = 1'b0;
        stall_execute = 1'b0;
        stall_mem     = 1'b0;
        flush_fetch   = 1'b0;
        flush_execute = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        iflush_req    = 1'b0;
        iflush_err    = iflush_err_q;
        fwd_rs1       = mem_valid & reg_write & (rd_m != 5'd0) & (rd_m == rs1_e);
        fwd_rs2       = mem_valid & reg_write & (rd_m != 5'd0) & (rd_m == rs2_e);

        case (state_q)
            RUN: begin
                if (dmem_busy) begin
                    stall_fetch   = 1'b1;
                    stall_execute = 1'b1;
                    stall_mem     = 1'b1;
                end else if (res && brj_taken) begin
                    redirect      = 1'b1;
                    redirect_addr = brj_addr;
                    flush_fetch   = 1'b1;
                    flush_execute = 1'b1;
                end else if (res && serialize) begin
                    saved_pc_d    = pc4;
                    flush_fetch   = 1'b1;
                    flush_execute = 1'b1;
                    cnt_d         = '0;
                    state_d       = fence_i ? FLUSH : REFETCH;
                end else if (imem_busy) begin
                    stall_fetch = 1'b1;
                end
            end
            FLUSH: begin
                iflush_req    = 1'b1;
                stall_fetch   = 1'b1;
                flush_execute = 1'b1;
                if (iflush_done) begin
                    cnt_d   = '0;
                    state_d = REFETCH;
                end else if (cnt_q == CNT_LAST) begin
                    iflush_err_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = REFETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REFETCH: begin
                redirect      = 1'b1;
                redirect_addr = saved_pc_q;
                flush_fetch   = 1'b1;
                state_d       = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (RST) begin
            stall_fetch   = 1'b0;
            stall_execute = 1'b0;
            stall_mem     = 1'b0;
            flush_fetch   = 1'b0;
            flush_execute = 1'b0;
            redirect      = 1'b0;
            redirect_addr = '0;
            iflush_req    = 1'b0;
            iflush_err    = 1'b0;
            fwd_rs1       = 1'b0;
            fwd_rs2       = 1'b0;
        end
    end

endmodule

// File: doc/stage3_hazard_ctrl.md
# stage3_hazard_ctrl

Pipeline controller for the three-stage (fetch / execute / mem) RV32I core. It resolves control transfers coming out of the mem stage and sequences the fence.i / CSR serialization flush. It also generates stall, flush and forwarding controls for the fetch→execute and execute→mem latches. It sits beside the stage3 datapath, reading the mem-stage outputs (`brj_addr`, `pc4`, `reg_write`, `rd_m`) and driving the pipeline latch enables and the fetch redirect.

## Interface
- `IFLUSH_TIMEOUT`, 255: maximum cycles spent in FLUSH waiting for `iflush_done` before forcing progress; must be ≥1.
- `CNT_W`, 8: width of the flush-wait counter; must satisfy 2^CNT_W > IFLUSH_TIMEOUT.

Ports:
- `CLK`  in  1  core clock; all state on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `imem_busy`  in  1  instruction fetch not complete.
- `dmem_busy`  in  1  mem-stage load/store not complete.
- `mem_valid`  in  1  mem stage holds a real instruction.
- `brj_taken`  in  1  mem-stage branch/jump taken.
- `brj_addr`  in  32  branch/jump target.
- `pc4`  in  32  mem-stage PC+4.
- `serialize`  in  1  mem-stage instruction is fence.i or a CSR access.
- `fence_i`  in  1  mem-stage instruction is fence.i; qualified by `serialize`.
- `iflush_done`  in  1  I-side flush acknowledge.
- `rs1_e`, `rs2_e`  in  5 each  execute-stage source registers.
- `rd_m`  in  5  mem-stage destination.
- `reg_write`  in  1  mem stage writes `rd_m`.
- `stall_fetch`, `stall_execute`, `stall_mem`  out  1 each  hold the corresponding stage/latch.
- `flush_fetch`  out  1  bubble into the fetch→execute latch.
- `flush_execute`  out  1  bubble into the execute→mem latch.
- `redirect`  out  1  load the fetch PC with `redirect_addr`.
- `redirect_addr`  out  32  new fetch PC.
- `iflush_req`  out  1  request I-side flush.
- `iflush_err`  out  1  sticky: a flush timed out.
- `fwd_rs1`, `fwd_rs2`  out  1 each  execute operand takes mem-stage `reg_wdata`.

## Operation
- FSM states: RUN, FLUSH, REFETCH. Reset enters RUN; the counter, saved PC and `iflush_err` are cleared.
- Resolve condition: `res = mem_valid & ~dmem_busy`.
- RUN, `dmem_busy=1`: assert all three stalls. No redirect or flush is issued; the decision is deferred.
- RUN, `res & brj_taken`:
  - `redirect=1`, `redirect_addr=brj_addr`, `flush_fetch=flush_execute=1`, same cycle (combinational).
  - State stays RUN.
  - `brj_taken` wins over `serialize` when both are set.
- RUN, `res & serialize & ~brj_taken`:
  - Capture `pc4` into `saved_pc`; assert `flush_fetch=flush_execute=1`.
  - Next state: FLUSH if `fence_i`, else REFETCH.
- RUN, `imem_busy=1` (no other event): `stall_fetch=1` only.
- FLUSH:
  - Outputs: `iflush_req=1`, `stall_fetch=1`, `flush_execute=1`, counter increments each cycle.
  - On `iflush_done`: go to REFETCH.
  - On counter = IFLUSH_TIMEOUT-1 without done: set `iflush_err`, go to REFETCH.
  - The counter clears on leaving FLUSH.
- REFETCH: one cycle with `redirect=1`, `redirect_addr=saved_pc`, `flush_fetch=1`; then RUN.
- Forwarding, combinational in every state:
  - `fwd_rs1 = mem_valid & reg_write & (rd_m!=0) & (rd_m==rs1_e)`.
  - `fwd_rs2` is the same with `rs2_e`.
- `redirect_addr` outputs 0 when `redirect=0`.

## Timing
- Reset values: every output is 0 (`redirect_addr` = 32'h0). State = RUN, counter = 0, `saved_pc` = 0.
- Branch latency: the redirect is in the same cycle as resolution. The fetch PC updates at the next edge.
- Serialization, non-fence:
  - Cycle T: resolve plus flushes.
  - T+1: REFETCH redirect to PC+4.
  - T+2: RUN.
- fence.i with `iflush_done` at cycle T+k (k≥1):
  - REFETCH at T+k+1.
  - Minimum total is 3 cycles from resolution to RUN.
- `iflush_done` asserted in RUN or REFETCH is ignored.
- `RST` asserted mid-FLUSH: all outputs drop to 0 immediately (asynchronous); state returns to RUN.
- `dmem_busy` in FLUSH/REFETCH is ignored; the mem stage is already a bubble.

## Test plan
- Reset: hold `RST` with random inputs → every output 0. Release with idle inputs → RUN, no stalls.
- Branch: `mem_valid=1`, `brj_taken=1`, `brj_addr=32'h0000_0200` → same-cycle `redirect=1`, addr 0x200, both flushes 1. Next cycle everything idle.
- Deferred branch: `brj_taken=1` with `dmem_busy=1` for 3 cycles → 3 cycles of all stalls with `redirect=0`; the redirect fires the cycle `dmem_busy` drops.
- CSR serialize: `serialize=1`, `fence_i=0`, `pc4=32'h104` → flushes at T; `redirect=1`, addr 0x104 at T+1; idle at T+2.
- fence.i: `pc4=32'h80`, `iflush_done` at T+4 → `iflush_req` high T+1..T+4, redirect to 0x80 at T+5. Repeat with no done and `IFLUSH_TIMEOUT=4` → `iflush_err` latches and the redirect still occurs.
- Forwarding: `rd_m=5`, `rs1_e=5`, `rs2_e=5`, `reg_write=1` → both fwd = 1. Then `rd_m=0` → both 0. Then `reg_write=0` → both 0.
